ex_div: RTL
===========

// Module: ex_div
// PURPOSE
//  Multi-cycle restoring divider used by the EX stage for DIV/DIVU. EX raises
//  start with the operands it receives from the ID/EX register. EX holds start
//  and the operands steady and raises stall_req to freeze the pipeline. The block
//  produces quotient/remainder for HI/LO after WIDTH+1 cycles. EX may drop the
//  operation at any time through annul (flush/exception).
// PARAMETERS
//  WIDTH  32  operand width. quotient, remainder and counter scale with it.
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        reset, synchronous, active-high
//  signed_div  in   1        1 = DIV (two's complement), 0 = DIVU
//  opdata1     in   WIDTH    dividend
//  opdata2     in   WIDTH    divisor
//  start       in   1        request. Held high with stable operands until ready.
//  annul       in   1        abort the current operation (flush)
//  result      out  2*WIDTH  {remainder, quotient}, i.e. {HI, LO}
//  ready       out  1        result valid
//  stall_req   out  1        comb: start & ~ready & ~annul
//  div_by_zero out  1        only with DIV_BYZERO_FLAG_EN
// BEHAVIOUR
//  Reset: state=IDLE, result=0, ready=0, cnt=0, internal regs=0 (div_by_zero=0).
//  States:
//   IDLE : if start & ~annul:
//          - opdata2==0 -> BY_ZERO;
//          - else -> ON with cnt=0. Latch |opdata1| and |opdata2| (abs only when
//            signed_div) and both sign bits.
//          Otherwise stay. ready=0, result=0.
//   BY_ZERO : next edge -> END. result=0, ready=1.
//   ON : if annul -> IDLE, ready=0, result=0, no result produced.
//        Else one restoring step per edge, MSB first: trial = partial
//        remainder (WIDTH+1 bits) - divisor. If non-negative, keep it and shift in
//        quotient bit 1; else shift in 0. cnt++.
//        On the edge where cnt==WIDTH -> END, apply sign fix, result, ready=1.
//   END : hold result, ready=1. When start==0 -> IDLE, ready=0, result=0.
//         While start stays high, result is held and no new op is taken.
//  Latency: start sampled at edge E0 -> ready high after E0+WIDTH+1 (33 for 32).
//           Divide by zero: ready after E0+2.
//  Sign fix (signed_div=1):
//   - quotient negated if opdata1 and opdata2 signs differ;
//   - remainder takes the sign of the dividend.
//  Boundaries:
//   - MIN/-1 signed: quotient wraps to 0x80000000, remainder 0, no flag.
//   - divisor 0 with signed_div either value -> result 0.
//   - annul in IDLE/END/BY_ZERO -> IDLE, ready=0, result=0.
//   - annul together with start in IDLE: annul wins, nothing launched.
//   - rst wins over every other input in every state, including mid-ON.
//   - Operands are sampled only in IDLE. Later operand changes are ignored.
//   - stall_req goes low the same cycle ready is high, so EX captures result once.
// CONFIGURATION
//  DIV_BYZERO_FLAG_EN defined:
//   - adds port div_by_zero, a registered flag.
//   - set to 1 on entering END from BY_ZERO, held while in END;
//     cleared on IDLE, annul or rst.
//  Not defined:
//   - port absent, no flag logic;
//   - divide by zero still returns result=0 through BY_ZERO.
// TESTING
//  1. DIVU 100/7, start held -> ready after 33 edges, result={32'd2,32'd14}.
//  2. DIV -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
//  3. DIV 0x80000000/0xFFFFFFFF -> result={32'h0,32'h80000000}, no hang.
//  4. DIVU 5/0 -> ready after 2 edges, result 0; div_by_zero=1 when macro defined.
//  5. annul at cnt=10 -> IDLE next edge, ready stays 0. A new start 3 cycles
//     later gives a correct result (123/10 -> {3,12}).
//  6. Keep start high 5 cycles past ready -> result stable; drop start ->
//     ready=0 next edge; rst mid-ON -> all outputs 0 next edge.

Source files
------------

// File: rtl/ex_div_if.sv
// Handshake and data bundle between the EX stage (master) and the divider (slave).
// DIV_BYZERO_FLAG_EN adds the registered div_by_zero flag to the bundle.
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               start;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall_req;
`ifdef DIV_BYZERO_FLAG_EN
    logic               div_by_zero;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready, stall_req, div_by_zero
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready, stall_req, div_by_zero
    );
`else
    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready, stall_req
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready, stall_req
    );
`endif
endinterface

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Define DIV_BYZERO_FLAG_EN to add the registered div_by_zero output.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_END} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
`ifdef DIV_BYZERO_FLAG_EN
    logic               flag_q, flag_d;
`endif

    logic [WIDTH-1:0]   abs1, abs2, quot_fix, rem_fix;
    logic [WIDTH:0]     shifted, trial;

    // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom.
    always_comb begin
        abs1     = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
        abs2     = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dsr_q};
        quot_fix = neg_quot_q ? -dvd_q : dvd_q;
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
        flag_d     = flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
`ifdef DIV_BYZERO_FLAG_EN
                flag_d   = 1'b0;
`endif
                if (bus.start && !bus.annul) begin
                    if (bus.opdata2 == '0) begin
                        state_d = S_BY_ZERO;
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = '0;
                        rem_d      = '0;
                        dvd_d      = abs1;
                        dsr_d      = abs2;
                        neg_quot_d = bus.signed_div && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                        neg_rem_d  = bus.signed_div && bus.opdata1[WIDTH-1];
                    end
                end
            end
            S_BY_ZERO: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (bus.annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_END;
`ifdef DIV_BYZERO_FLAG_EN
                    flag_d  = 1'b1;
`endif
                end
            end
            S_ON: begin
                if (bus.annul) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d  = S_END;
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                end else begin
                    // A negative trial means the divisor did not fit: keep the shifted value.
                    rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_END: begin
                if (bus.annul || !bus.start) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
`ifdef DIV_BYZERO_FLAG_EN
                    flag_d   = 1'b0;
`endif
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
            flag_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
`ifdef DIV_BYZERO_FLAG_EN
            flag_q     <= flag_d;
`endif
        end
    end

    assign bus.result    = result_q;
    assign bus.ready     = ready_q;
    assign bus.stall_req = bus.start & ~ready_q & ~bus.annul;
`ifdef DIV_BYZERO_FLAG_EN
    assign bus.div_by_zero = flag_q;
`endif

endmodule
